wb_bus_arbiter: RTL and testbench

Two-master Wishbone arbiter sharing the CPLD register bus (5-bit address, 8-bit data) between the host bridge (master 0) and the debug/serial master (master 1). Ownership is fair round-robin, held for a whole `cyc` bus cycle. A watchdog terminates any strobe the slave fails to acknowledge. The block sits between the two masters and the register-slave address decoder.

---
 rtl/wb_bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_wb_bus_arbiter.sv | 367 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_arbiter.sv
// Two-master Wishbone arbiter: round-robin ownership held for a whole cyc,
// with a watchdog that terminates strobes the slave never acknowledges.
module wb_bus_arbiter #(
  parameter int ADR_W   = 5,
  parameter int DAT_W   = 8,
  parameter int TIMEOUT = 15
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_n_i,
  input  logic             m0_cyc_i,
  input  logic             m0_stb_i,
  input  logic             m0_we_i,
  input  logic [ADR_W-1:0] m0_adr_i,
  input  logic [DAT_W-1:0] m0_dat_i,
  output logic [DAT_W-1:0] m0_dat_o,
  output logic             m0_ack_o,
  output logic             m0_err_o,
  input  logic             m1_cyc_i,
  input  logic             m1_stb_i,
  input  logic             m1_we_i,
  input  logic [ADR_W-1:0] m1_adr_i,
  input  logic [DAT_W-1:0] m1_dat_i,
  output logic [DAT_W-1:0] m1_dat_o,
  output logic             m1_ack_o,
  output logic             m1_err_o,
  output logic             s_cyc_o,
  output logic             s_stb_o,
  output logic             s_we_o,
  output logic [ADR_W-1:0] s_adr_o,
  output logic [DAT_W-1:0] s_dat_o,
  input  logic [DAT_W-1:0] s_dat_i,
  input  logic             s_ack_i,
  output logic             busy_o,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a master owns the bus from grant until it drops cyc; each
  // transfer is stb held until the cycle in which ack (or err) is returned.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_last;
  logic             w_last_nxt;
  logic [7:0]       r_wd;
  logic [7:0]       w_wd_nxt;

  logic             w_own0;
  logic             w_own1;
  logic             w_own_cyc;
  logic             w_own_stb;
  logic             w_own_we;
  logic [ADR_W-1:0] w_own_adr;
  logic [DAT_W-1:0] w_own_dat;
  logic             w_timeout;

  assign w_own0 = (r_state == OWN0);
  assign w_own1 = (r_state == OWN1);

  always_comb begin
    w_own_cyc = 1'b0;
    w_own_stb = 1'b0;
    w_own_we  = 1'b0;
    w_own_adr = '0;
    w_own_dat = '0;
    if (w_own0) begin
      w_own_cyc = m0_cyc_i;
      w_own_stb = m0_stb_i;
      w_own_we  = m0_we_i;
      w_own_adr = m0_adr_i;
      w_own_dat = m0_dat_i;
    end else if (w_own1) begin
      w_own_cyc = m1_cyc_i;
      w_own_stb = m1_stb_i;
      w_own_we  = m1_we_i;
      w_own_adr = m1_adr_i;
      w_own_dat = m1_dat_i;
    end
  end

  // An ack arriving in the expiry cycle wins over the timeout.
  assign w_timeout = (w_own0 | w_own1) & w_own_stb & ~s_ack_i & (r_wd == WD_LIMIT);

  assign s_cyc_o = w_own_cyc;
  assign s_stb_o = w_own_stb & ~w_timeout;
  assign s_we_o  = w_own_we;
  assign s_adr_o = w_own_adr;
  assign s_dat_o = w_own_dat;

  assign m0_ack_o = w_own0 & s_ack_i;
  assign m1_ack_o = w_own1 & s_ack_i;
  assign m0_err_o = w_own0 & w_timeout;
  assign m1_err_o = w_own1 & w_timeout;
  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

  assign busy_o      = (r_state != IDLE);
  assign dbg_state_o = r_state;

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    case (r_state)
      IDLE: begin
        // On contention the master that did not win last time gets the bus.
        if (m0_cyc_i && m1_cyc_i) begin
          if (r_last) begin
            w_state_nxt = OWN0;
            w_last_nxt  = 1'b0;
          end else begin
            w_state_nxt = OWN1;
            w_last_nxt  = 1'b1;
          end
        end else if (m0_cyc_i) begin
          w_state_nxt = OWN0;
          w_last_nxt  = 1'b0;
        end else if (m1_cyc_i) begin
          w_state_nxt = OWN1;
          w_last_nxt  = 1'b1;
        end
      end
      OWN0: if (!m0_cyc_i) w_state_nxt = IDLE;
      OWN1: if (!m1_cyc_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_wd_nxt = r_wd + 8'd1;
    if (!(w_own0 | w_own1) || s_ack_i || !w_own_stb || w_timeout) begin
      w_wd_nxt = 8'd0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_wd    <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_last  <= w_last_nxt;
      r_wd    <= w_wd_nxt;
    end
  end

endmodule

// File: tb/tb_wb_bus_arbiter.sv
// Bench for wb_bus_arbiter: vector table, directed corner sequences and a
// randomized run checked against an ownership/strobe-age reference model.
module tb_wb_bus_arbiter;

  localparam int ADR_W   = 5;
  localparam int DAT_W   = 8;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
  logic [ADR_W-1:0] m0_adr;
  logic [DAT_W-1:0] m0_wdat, m0_rdat;
  logic             m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
  logic [ADR_W-1:0] m1_adr;
  logic [DAT_W-1:0] m1_wdat, m1_rdat;
  logic             s_cyc, s_stb, s_we, s_ack, busy;
  logic [ADR_W-1:0] s_adr;
  logic [DAT_W-1:0] s_wdat, s_rdat;
  logic [1:0]       dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  wb_bus_arbiter #(.ADR_W(ADR_W), .DAT_W(DAT_W), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we), .m0_adr_i(m0_adr),
    .m0_dat_i(m0_wdat), .m0_dat_o(m0_rdat), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we), .m1_adr_i(m1_adr),
    .m1_dat_i(m1_wdat), .m1_dat_o(m1_rdat), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_adr_o(s_adr),
    .s_dat_o(s_wdat), .s_dat_i(s_rdat), .s_ack_i(s_ack), .busy_o(busy),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  typedef struct packed {
    logic             s_cyc;
    logic             s_stb;
    logic             s_we;
    logic [ADR_W-1:0] s_adr;
    logic [DAT_W-1:0] s_dat;
    logic             m0_ack;
    logic             m0_err;
    logic             m1_ack;
    logic             m1_err;
    logic             busy;
    logic [DAT_W-1:0] m0_rd;
    logic [DAT_W-1:0] m1_rd;
  } out_t;

  // ---------------- reference model ----------------
  int mdl_owner = -1;
  int mdl_last  = 1;
  int mdl_age   = 0;

  task automatic model_reset();
    mdl_owner = -1;
    mdl_last  = 1;
    mdl_age   = 0;
  endtask

  function automatic out_t model_out();
    logic             c[2];
    logic             s[2];
    logic             w[2];
    logic [ADR_W-1:0] a[2];
    logic [DAT_W-1:0] d[2];
    logic             to;
    out_t             o;
    c = '{m0_cyc, m1_cyc};
    s = '{m0_stb, m1_stb};
    w = '{m0_we, m1_we};
    a = '{m0_adr, m1_adr};
    d = '{m0_wdat, m1_wdat};
    o = '0;
    o.m0_rd = s_rdat;
    o.m1_rd = s_rdat;
    if (mdl_owner >= 0) begin
      to      = s[mdl_owner] && !s_ack && (mdl_age == TIMEOUT - 1);
      o.busy  = 1'b1;
      o.s_cyc = c[mdl_owner];
      o.s_stb = s[mdl_owner] && !to;
      o.s_we  = w[mdl_owner];
      o.s_adr = a[mdl_owner];
      o.s_dat = d[mdl_owner];
      if (mdl_owner == 0) begin
        o.m0_ack = s_ack;
        o.m0_err = to;
      end else begin
        o.m1_ack = s_ack;
        o.m1_err = to;
      end
    end
    return o;
  endfunction

  task automatic model_step();
    logic c[2];
    logic s[2];
    logic to;
    c = '{m0_cyc, m1_cyc};
    s = '{m0_stb, m1_stb};
    if (mdl_owner >= 0) begin
      to = s[mdl_owner] && !s_ack && (mdl_age == TIMEOUT - 1);
      if (s[mdl_owner] && !s_ack && !to) mdl_age++;
      else mdl_age = 0;
      if (!c[mdl_owner]) begin
        mdl_owner = -1;
        mdl_age   = 0;
      end
    end else begin
      mdl_age = 0;
      if (c[0] && c[1]) mdl_owner = 1 - mdl_last;
      else if (c[0])    mdl_owner = 0;
      else if (c[1])    mdl_owner = 1;
      if (mdl_owner >= 0) mdl_last = mdl_owner;
    end
  endtask

  // ---------------- driver tasks ----------------
  function automatic out_t sample();
    out_t o;
    o.s_cyc  = s_cyc;
    o.s_stb  = s_stb;
    o.s_we   = s_we;
    o.s_adr  = s_adr;
    o.s_dat  = s_wdat;
    o.m0_ack = m0_ack;
    o.m0_err = m0_err;
    o.m1_ack = m1_ack;
    o.m1_err = m1_err;
    o.busy   = busy;
    o.m0_rd  = m0_rdat;
    o.m1_rd  = m1_rdat;
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    {m0_cyc, m0_stb, m0_we, m1_cyc, m1_stb, m1_we, s_ack} = '0;
    m0_adr = '0; m1_adr = '0; m0_wdat = '0; m1_wdat = '0; s_rdat = '0;
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic next_cycle();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic rst, c0, s0, c1, s1, ack;
    int   own;  // 0 none, 1 master 0, 2 master 1
    logic ack0, err0, ack1, err1;
  } vec_t;

  vec_t tbl[19];

  function automatic out_t vec_expect(input vec_t v);
    out_t o;
    o = '0;
    o.m0_rd = 8'h05;
    o.m1_rd = 8'h05;
    if (v.own == 1) begin
      o.busy = 1'b1; o.s_cyc = v.c0; o.s_stb = v.s0 & ~v.err0;
      o.s_we = 1'b0; o.s_adr = 5'd3; o.s_dat = 8'hA0;
    end else if (v.own == 2) begin
      o.busy = 1'b1; o.s_cyc = v.c1; o.s_stb = v.s1 & ~v.err1;
      o.s_we = 1'b1; o.s_adr = 5'd6; o.s_dat = 8'h11;
    end
    o.m0_ack = v.ack0; o.m0_err = v.err0;
    o.m1_ack = v.ack1; o.m1_err = v.err1;
    return o;
  endfunction

  initial begin
    int   err_at, err_cnt, ack_cnt, early_err;
    logic stb_at_err, stb_before;
    bit   dead;

    //            rst c0 s0 c1 s1 ack own a0 e0 a1 e1
    tbl[0]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 0, 1'b0,1'b0,1'b0,1'b0};
    tbl[1]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 1, 1'b0,1'b0,1'b0,1'b0};
    tbl[2]  = '{1'b0,1'b1,1'b1,1'b0,1'b0,1'b1, 1, 1'b1,1'b0,1'b0,1'b0};
    tbl[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1, 1'b0,1'b0,1'b0,1'b0};
    tbl[4]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 0, 1'b0,1'b0,1'b0,1'b0};
    tbl[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 0, 1'b0,1'b0,1'b0,1'b0};
    tbl[6]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 0, 1'b0,1'b0,1'b0,1'b0};
    tbl[7]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 1, 1'b0,1'b0,1'b0,1'b0};
    tbl[8]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b1, 1, 1'b1,1'b0,1'b0,1'b0};
    tbl[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 1, 1'b0,1'b0,1'b0,1'b0};
    tbl[10] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 0, 1'b0,1'b0,1'b0,1'b0};
    tbl[11] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0, 2, 1'b0,1'b0,1'b0,1'b0};
    tbl[12] = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b1, 2, 1'b0,1'b0,1'b1,1'b0};
    tbl[13] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 2, 1'b0,1'b0,1'b0,1'b0};
    tbl[14] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 0, 1'b0,1'b0,1'b0,1'b0};
    tbl[15] = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 0, 1'b0,1'b0,1'b0,1'b0};
    tbl[16] = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b0, 1, 1'b0,1'b0,1'b0,1'b0};
    tbl[17] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 1, 1'b0,1'b0,1'b0,1'b0};
    tbl[18] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0, 0, 1'b0,1'b0,1'b0,1'b0};

    clear_inputs();
    @(negedge clk);
    #2;
    chk("reset_outputs", 64'(sample()), 64'(out_t'('0)));
    @(negedge clk);
    do_reset();

    // ---- table: single read, contention, turnaround, round-robin ----
    m0_we = 1'b0; m0_adr = 5'd3; m0_wdat = 8'hA0;
    m1_we = 1'b1; m1_adr = 5'd6; m1_wdat = 8'h11;
    s_rdat = 8'h05;
    for (int i = 0; i < 19; i++) begin
      rst_n = ~tbl[i].rst;
      if (tbl[i].rst) model_reset();
      m0_cyc = tbl[i].c0; m0_stb = tbl[i].s0;
      m1_cyc = tbl[i].c1; m1_stb = tbl[i].s1;
      s_ack  = tbl[i].ack;
      #2;
      chk($sformatf("vec%0d", i), 64'(sample()), 64'(vec_expect(tbl[i])));
      next_cycle();
    end
    rst_n = 1'b1;

    // ---- master 1 burst of four writes, master 0 waiting ----
    do_reset();
    m1_we = 1'b1; m1_adr = 5'd6; m1_cyc = 1'b1; m1_stb = 1'b1; m1_wdat = 8'h11;
    m0_we = 1'b0; m0_adr = 5'd3;
    #2;
    chk("burst_idle", 64'(busy), 64'(0));
    next_cycle();
    for (int i = 0; i < 4; i++) begin
      m1_wdat = 8'(8'h11 + i);
      m0_cyc = 1'b1; m0_stb = 1'b1;
      s_ack = 1'b1;
      #2;
      chk($sformatf("burst_xfer%0d", i),
          64'({s_stb, s_we, s_adr, s_wdat, m1_ack, m0_ack, m0_err}),
          64'({1'b1, 1'b1, 5'd6, 8'(8'h11 + i), 1'b1, 1'b0, 1'b0}));
      next_cycle();
    end
    m1_cyc = 1'b0; m1_stb = 1'b0; s_ack = 1'b0;
    #2;
    chk("burst_release", 64'({busy, s_cyc, s_stb, m0_ack}), 64'({1'b1, 1'b0, 1'b0, 1'b0}));
    next_cycle();
    #2;
    chk("burst_turnaround", 64'({busy, s_cyc}), 64'({1'b0, 1'b0}));
    next_cycle();
    #2;
    chk("burst_m0_grant", 64'({busy, s_cyc, s_stb, s_we, s_adr}),
        64'({1'b1, 1'b1, 1'b1, 1'b0, 5'd3}));
    next_cycle();

    // ---- watchdog: slave never acks ----
    do_reset();
    m0_adr = 5'd3; m0_cyc = 1'b1; m0_stb = 1'b1;
    next_cycle();
    err_at = -1; err_cnt = 0; ack_cnt = 0; stb_at_err = 1'b1; stb_before = 1'b0;
    for (int k = 1; k <= 24; k++) begin
      m0_cyc = (err_cnt == 0);
      m0_stb = (err_cnt == 0);
      #2;
      if (k == 14) stb_before = s_stb;
      if (m0_err) begin
        err_cnt++;
        if (err_at < 0) begin
          err_at = k;
          stb_at_err = s_stb;
        end
      end
      if (m0_ack) ack_cnt++;
      next_cycle();
    end
    chk("wd_err_cycle", 64'(err_at), 64'(TIMEOUT));
    chk("wd_err_count", 64'(err_cnt), 64'(1));
    chk("wd_stb_at_err", 64'(stb_at_err), 64'(0));
    chk("wd_stb_before", 64'(stb_before), 64'(1));
    chk("wd_no_ack", 64'(ack_cnt), 64'(0));

    // ---- ack arriving exactly at watchdog expiry ----
    do_reset();
    m0_adr = 5'd3; m0_cyc = 1'b1; m0_stb = 1'b1;
    next_cycle();
    early_err = 0;
    for (int k = 1; k <= TIMEOUT; k++) begin
      s_ack = (k == TIMEOUT);
      #2;
      if (k < TIMEOUT && m0_err) early_err++;
      if (k == TIMEOUT)
        chk("wd_ack_wins", 64'({m0_ack, m0_err, s_stb}), 64'({1'b1, 1'b0, 1'b1}));
      next_cycle();
    end
    chk("wd_ack_early_err", 64'(early_err), 64'(0));

    // ---- asynchronous reset while master 1 owns the bus ----
    do_reset();
    m1_we = 1'b1; m1_adr = 5'd6; m1_wdat = 8'h3C; m1_cyc = 1'b1; m1_stb = 1'b1;
    s_rdat = 8'h5A;
    next_cycle();
    #2;
    chk("rst_pre_owned", 64'({busy, s_stb, s_adr}), 64'({1'b1, 1'b1, 5'd6}));
    s_ack = 1'b1;
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("rst_async_outputs",
        64'({s_cyc, s_stb, s_we, s_adr, s_wdat, m0_ack, m0_err, m1_ack, m1_err, busy}), 64'(0));
    chk("rst_rdata_follow", 64'({m0_rdat, m1_rdat}), 64'({8'h5A, 8'h5A}));
    next_cycle();
    rst_n = 1'b1;
    s_ack = 1'b0;
    m0_adr = 5'd3; m0_we = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
    #2;
    chk("rst_release_idle", 64'(busy), 64'(0));
    next_cycle();
    #2;
    chk("rst_m0_wins", 64'({busy, s_adr, s_we, m1_ack}), 64'({1'b1, 5'd3, 1'b0, 1'b0}));
    next_cycle();

    // ---- randomized run against the reference model ----
    do_reset();
    dead = 1'b0;
    for (int i = 0; i < 600; i++) begin
      dead = ((i % 80) >= 50);
      m0_cyc = m0_cyc ? ($urandom_range(0, dead ? 31 : 7) != 0) : ($urandom_range(0, 3) == 0);
      m1_cyc = m1_cyc ? ($urandom_range(0, dead ? 31 : 7) != 0) : ($urandom_range(0, 3) == 0);
      m0_stb = m0_cyc ? (dead || $urandom_range(0, 4) != 0) : ($urandom_range(0, 9) == 0);
      m1_stb = m1_cyc ? (dead || $urandom_range(0, 4) != 0) : ($urandom_range(0, 9) == 0);
      m0_we = 1'($urandom_range(0, 1));
      m1_we = 1'($urandom_range(0, 1));
      m0_adr = 5'($urandom_range(0, 31));
      m1_adr = 5'($urandom_range(0, 31));
      m0_wdat = 8'($urandom_range(0, 255));
      m1_wdat = 8'($urandom_range(0, 255));
      s_rdat = 8'($urandom_range(0, 255));
      s_ack = dead ? 1'b0 : ($urandom_range(0, 2) == 0);
      #2;
      chk($sformatf("rand%0d", i), 64'(sample()), 64'(model_out()));
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
